// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and sends it as a start/LSB-first data/stop serial frame.
// Defining FIFO_UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state_dbg
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                parity;
`endif
  logic                baud_end;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign state_dbg = state;

  // shreg holds the bits not yet driven onto tx; tx is loaded from shreg[0] at each bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (enable && !fifo_empty) begin
            state   <= POP;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg    <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity   <= ^fifo_data;
`endif
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            baud_cnt   <= '0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, expected-byte queue and per-cycle serial line model.
// Honours FIFO_UART_TX_PARITY_EN when building the expected frame.
module tb_fifo_uart_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS  = DATA_W + 3;
`else
  localparam int NBITS  = DATA_W + 2;
`endif

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_rd;
  logic              tx;
  logic              busy;
  logic              frame_done;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem [0:255];
  logic [7:0]        wr_ptr = '0;
  logic [7:0]        rd_ptr = '0;
  int                pop_count = 0;
  int                bad_pops  = 0;
  int                pushed    = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // Registered-read FIFO: data_out takes the head at the edge where rd is high.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      if (fifo_empty) begin
        bad_pops <= bad_pops + 1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 8'd1;
        pop_count <= pop_count + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(b);
    pushed++;
  endtask

  // Waits up to limit negedges for the pop pulse; returns how many were needed.
  task automatic wait_pop(input int limit, output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < limit) begin
      @(negedge clk);
      waited++;
      if (fifo_rd === 1'b1) found = 1'b1;
    end
    chk("pop_seen", {31'd0, found}, 32'd1);
    if (found) chk("pop_tx_idle", {31'd0, tx}, 32'd1);
  endtask

  // Entered just after the POP-cycle negedge; ends at the negedge where frame_done is expected.
  task automatic run_frame(input int drop_at);
    logic [DATA_W-1:0] b;
    logic              bits[$];
    if (exp_q.size() == 0) begin
      chk("exp_q_nonempty", 32'd0, 32'd1);
    end else begin
      b = exp_q.pop_front();
      bits.push_back(1'b0);
      for (int k = 0; k < DATA_W; k++) bits.push_back(b[k]);
`ifdef FIFO_UART_TX_PARITY_EN
      bits.push_back(^b);
`endif
      bits.push_back(1'b1);
      @(negedge clk);
      chk("load_tx", {31'd0, tx}, 32'd1);
      chk("load_rd", {31'd0, fifo_rd}, 32'd0);
      for (int i = 0; i < NBITS * CPB; i++) begin
        @(negedge clk);
        chk($sformatf("byte%02h_bit%0d_cyc%0d", b, i / CPB, i % CPB), {31'd0, tx}, {31'd0, bits[i / CPB]});
        chk("frame_busy", {31'd0, busy}, 32'd1);
        chk("frame_done_early", {31'd0, frame_done}, 32'd0);
        chk("frame_no_pop", {31'd0, fifo_rd}, 32'd0);
        if (i == drop_at) enable = 1'b0;
      end
      @(negedge clk);
      chk("done_pulse", {31'd0, frame_done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_tx", {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    int w;
    int n;
    #2 rst = 1'b0;
    enable = 1'b1;
    push(8'hA5);
    repeat (10) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
    end
    rst = 1'b1;
    wait_pop(5, w);
    chk("start_latency", w, 32'd1);
    run_frame(-1);
    chk("pops_after_a5", pop_count, 32'd1);

    // Parity-sensitive byte.
    push(8'h07);
    wait_pop(2, w);
    run_frame(-1);

    // Empty FIFO with enable high, then data arrives mid-wait.
    repeat (50) begin
      @(negedge clk);
      chk("empty_rd", {31'd0, fifo_rd}, 32'd0);
      chk("empty_busy", {31'd0, busy}, 32'd0);
    end
    push(8'($urandom_range(0, 255)));
    @(negedge clk);
    chk("late_start_rd", {31'd0, fifo_rd}, 32'd1);
    run_frame(-1);

    // Eight preloaded bytes drained back to back.
    for (int k = 1; k <= 8; k++) push(8'(k));
    for (int k = 1; k <= 8; k++) begin
      wait_pop(3, w);
      chk($sformatf("b2b_gap_%0d", k), w, 32'd1);
      run_frame(-1);
    end
    chk("b2b_empty", {31'd0, fifo_empty}, 32'd1);
    chk("b2b_pops", pop_count, 32'd11);

    // Randomized bursts with random idle gaps.
    repeat (3) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)));
      for (int k = 0; k < n; k++) begin
        wait_pop(3, w);
        chk("rand_gap", w, 32'd1);
        run_frame(-1);
      end
    end

    // enable dropped during START: frame completes, nothing further is popped.
    push(8'h3C);
    push(8'hC3);
    wait_pop(2, w);
    run_frame(2);
    repeat (20) begin
      @(negedge clk);
      chk("disabled_rd", {31'd0, fifo_rd}, 32'd0);
      chk("disabled_busy", {31'd0, busy}, 32'd0);
    end
    chk("disabled_nonempty", {31'd0, fifo_empty}, 32'd0);
    enable = 1'b1;
    wait_pop(2, w);
    chk("reenable_latency", w, 32'd1);
    run_frame(-1);

    // Reset in the middle of an all-zero data byte.
    push(8'h00);
    wait_pop(2, w);
    @(negedge clk);
    repeat (CPB + 6) @(negedge clk);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    chk("hold_rst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    push(8'h5A);
    wait_pop(2, w);
    chk("post_rst_latency", w, 32'd1);
    run_frame(-1);

    repeat (5) @(negedge clk);
    chk("final_pops", pop_count, pushed);
    chk("final_bad_pops", bad_pops, 32'd0);
    chk("final_empty", {31'd0, fifo_empty}, 32'd1);
    chk("final_exp_q", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
